// File: rtl/div_iter_pkg.sv
// div_iter_pkg: shared state encoding, default width and HI/LO placement for the divider
package div_iter_pkg;
  localparam int DIV_DATA_W = 32;
  localparam int LO_OFS     = 0;
  localparam int HI_OFS     = DIV_DATA_W;
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DIVZERO = 2'd1,
    ON      = 2'd2,
    END     = 2'd3
  } state_t;
endpackage

// File: rtl/div_step.sv
// div_step: one combinational restoring step on a {remainder, dividend/quotient} accumulator
module div_step #(
  parameter int W = 32
) (
  input  logic [2*W-1:0] acc_i,
  input  logic [W-1:0]   dvs_i,
  output logic [2*W-1:0] acc_o,
  output logic           q_o
);
  logic [W:0] rem_sh, diff;
  assign rem_sh = acc_i[2*W-1:W-1];
  // rem < divisor always holds, so the top bit of the W+1 bit difference is the borrow
  assign diff   = rem_sh - {1'b0, dvs_i};
  assign q_o    = ~diff[W];
  assign acc_o  = {q_o ? diff[W-1:0] : rem_sh[W-1:0], acc_i[W-2:0], q_o};
endmodule

// File: rtl/div_iter.sv
// div_iter: multi-cycle radix-2 restoring divider for DIV/DIVU; result is {HI=remainder, LO=quotient}
module div_iter
  import div_iter_pkg::*;
#(
  parameter int DATA_W = DIV_DATA_W,
  parameter int CNT_W  = 6
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                start_i,
  input  logic                signed_i,
  input  logic [DATA_W-1:0]   opdata1_i,
  input  logic [DATA_W-1:0]   opdata2_i,
  input  logic                annul_i,
  output logic [2*DATA_W-1:0] result_o,
  output logic                ready_o,
  output logic                stall_o
);
  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   rem_q, rem_d, dvd_q, dvd_d, dvs_q, dvs_d;
  logic                sgn_q, sgn_d, s1_q, s1_d, s2_q, s2_d, ready_q, ready_d;
  logic [2*DATA_W-1:0] result_q, result_d, step_acc;
  logic                qbit;
  logic [DATA_W-1:0]   q_raw, r_raw, q_fix, r_fix;

  div_step #(.W(DATA_W)) u_step (
    .acc_i({rem_q, dvd_q}),
    .dvs_i(dvs_q),
    .acc_o(step_acc),
    .q_o  (qbit)
  );

  assign q_raw    = {step_acc[DATA_W-1:1], qbit};
  assign r_raw    = step_acc[2*DATA_W-1:DATA_W];
  assign q_fix    = (sgn_q & (s1_q ^ s2_q)) ? -q_raw : q_raw;
  assign r_fix    = (sgn_q & s1_q) ? -r_raw : r_raw;
  assign stall_o  = start_i & ~ready_q & ~annul_i;
  assign ready_o  = ready_q;
  assign result_o = result_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    dvd_d    = dvd_q;
    dvs_d    = dvs_q;
    sgn_d    = sgn_q;
    s1_d     = s1_q;
    s2_d     = s2_q;
    ready_d  = 1'b0;
    result_d = result_q;
    if (annul_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: if (start_i) begin
          if (opdata2_i == '0) begin
            state_d = DIVZERO;
          end else begin
            state_d = ON;
            // 0x80000000 negates to itself, which is the correct magnitude read as unsigned
            dvd_d   = (signed_i & opdata1_i[DATA_W-1]) ? -opdata1_i : opdata1_i;
            dvs_d   = (signed_i & opdata2_i[DATA_W-1]) ? -opdata2_i : opdata2_i;
            rem_d   = '0;
            cnt_d   = '0;
            sgn_d   = signed_i;
            s1_d    = opdata1_i[DATA_W-1];
            s2_d    = opdata2_i[DATA_W-1];
          end
        end
        DIVZERO: begin
          state_d  = END;
          ready_d  = 1'b1;
          result_d = '0;
        end
        ON: begin
          rem_d = r_raw;
          dvd_d = q_raw;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(DATA_W - 1)) begin
            state_d                      = END;
            ready_d                      = 1'b1;
            result_d[HI_OFS +: DATA_W]   = r_fix;
            result_d[LO_OFS +: DATA_W]   = q_fix;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      rem_q    <= '0;
      dvd_q    <= '0;
      dvs_q    <= '0;
      sgn_q    <= 1'b0;
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      ready_q  <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      dvd_q    <= dvd_d;
      dvs_q    <= dvs_d;
      sgn_q    <= sgn_d;
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      ready_q  <= ready_d;
      result_q <= result_d;
    end
  end
endmodule

// File: doc/div_iter.md
Name: div_iter

Overview:
- Multi-cycle radix-2 restoring divider for DIV/DIVU in the E stage of the MIPS pipeline.
- It is the producer of the divide stall consumed by the hazard unit: the pipeline holds E/M/W while the divider is busy, and releases when the result is ready.
- The result is delivered as {HI=remainder, LO=quotient} to the E-stage HI/LO write path.

Parameters:
- DATA_W, 32, operand width; result is 2*DATA_W.
- CNT_W, 6, iteration counter width; must hold DATA_W.

Ports:
- clk  input  1  system clock.
- resetn  input  1  asynchronous, active-low reset.
- start_i  input  1  E-stage instruction is DIV/DIVU; held high while stalled.
- signed_i  input  1  1 = DIV (two's complement), 0 = DIVU.
- opdata1_i  input  DATA_W  dividend (rs).
- opdata2_i  input  DATA_W  divisor (rt).
- annul_i  input  1  exception flush; aborts any operation in progress.
- result_o  output  2*DATA_W  {remainder, quotient}.
- ready_o  output  1  result valid; registered.
- stall_o  output  1  stall request to the hazard unit.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on resetn.
- Reset values: state IDLE, ready_o 0, result_o 0, counter 0, internal dividend/divisor/partial-remainder registers 0.
- stall_o = start_i & ~ready_o & ~annul_i. This is combinational and is the only combinational output.
- States: IDLE, DIVZERO, ON, END.
- IDLE:
  - start_i=1, annul_i=0, divisor==0 -> DIVZERO.
  - start_i=1, annul_i=0, divisor!=0 -> ON. On this transition, latch |dividend| and |divisor|; the absolute value is taken only when signed_i=1. Also latch signed_i and both operand sign bits, clear the partial remainder, and set counter=0.
  - Otherwise stay in IDLE.
- DIVZERO: next edge -> END, with result_o = 0.
- ON: each edge performs one restoring step.
  - Shift {rem, dvd} left by 1, then trial-subtract the divisor from rem.
  - If the subtraction does not borrow, rem = difference and shift in quotient bit 1; else shift in 0.
  - counter increments each step.
  - On the edge where counter==DATA_W-1, transition to END and register result_o with sign correction:
    - quotient is negated if signed and the operand signs differ;
    - remainder takes the sign of the dividend.
- END: ready_o=1 for exactly one cycle; next edge -> IDLE unconditionally. result_o holds its value until the next completed operation.
- Latency (cycle 0 = first cycle start_i is sampled high):
  - normal: ready_o high in cycle DATA_W+1 (33); stall_o high in cycles 0..32.
  - divide-by-zero: ready_o high in cycle 2.
- Back-to-back divides: the second start_i, sampled in IDLE the cycle after END, begins a new operation. No result is reused.
- Operands are sampled only on the IDLE->ON/DIVZERO edge; changes during ON are ignored.
- annul_i=1 in any state:
  - next state is IDLE, ready_o 0 next cycle, stall_o 0 immediately;
  - result_o is unchanged.
  - annul_i has priority over start_i in IDLE.
- Arithmetic boundaries:
  - 0x80000000 / 0xFFFFFFFF signed -> quotient 0x80000000, remainder 0. Quotient negation wraps; no overflow flag.
  - Negation uses two's complement on DATA_W bits. |0x80000000| = 0x80000000 treated as unsigned.
- resetn asserted mid-operation: immediate return to reset values.

Decomposition:
- Shared package:
  - state encoding constants (IDLE/DIVZERO/ON/END, 2 bits);
  - DATA_W default;
  - HI/LO field offsets within result_o.
- One natural sub-module, div_step: combinational single restoring step. Inputs are {rem, dvd} and divisor; outputs are the next {rem, dvd} and the quotient bit. It is instantiated once, iterated by the FSM.

Test Plan:
- DIVU 100 / 7, start held until ready -> ready_o in cycle 33; result_o = {0x00000002, 0x0000000E}; stall_o high cycles 0..32, low at 33.
- DIV -7 (0xFFFFFFF9) / 2 -> result_o = {0xFFFFFFFF, 0xFFFFFFFD}. Also DIV 7 / -2 -> {0x00000001, 0xFFFFFFFD}.
- DIV 0x80000000 / 0xFFFFFFFF -> {0x00000000, 0x80000000}. DIVU 0xFFFFFFFF / 1 -> {0, 0xFFFFFFFF}.
- Divisor 0 (either signedness) -> ready_o in cycle 2; result_o = 0; stall_o low from cycle 2.
- annul_i pulsed in cycle 10 of a divide:
  - stall_o 0 in cycle 10; state IDLE; ready_o never asserts; result_o keeps its prior value.
  - A new start in cycle 12 completes normally in cycle 45.
- Two consecutive divides (start high, low for 0 cycles between): the second completes 34 cycles after the first's END with the correct independent result. resetn low at cycle 5 of an operation -> all outputs 0 asynchronously.
